// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for alu_pipe.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDC = 4'h1,
        OP_SUB  = 4'h2,
        OP_SUBB = 4'h3,
        OP_INC  = 4'h4,
        OP_DEC  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_NOT  = 4'h9,
        OP_SHL  = 4'hA,
        OP_SHR  = 4'hB,
        OP_ASR  = 4'hC,
        OP_ROL  = 4'hD,
        OP_PASS = 4'hE,
        OP_CMP  = 4'hF
    } alu_op_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/bk_adder.sv
// Combinational Brent-Kung prefix adder; W must be a power of two.
module bk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         CI,
    output logic [W-1:0] S,
    output logic         CO
);
    localparam int L = $clog2(W);

    logic [W-1:0] prop_s;
    logic [W-1:0] grp_g_s;
    logic [W-1:0] grp_p_s;

    // Up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes.
    always_comb begin
        prop_s     = X ^ Y;
        grp_g_s    = X & Y;
        grp_g_s[0] = grp_g_s[0] | (prop_s[0] & CI);
        grp_p_s    = prop_s;
        for (int l = 0; l < L; l++) begin
            for (int i = (2 ** (l + 1)) - 1; i < W; i += 2 ** (l + 1)) begin
                grp_g_s[i] = grp_g_s[i] | (grp_p_s[i] & grp_g_s[i - (2 ** l)]);
                grp_p_s[i] = grp_p_s[i] & grp_p_s[i - (2 ** l)];
            end
        end
        for (int l = L - 2; l >= 0; l--) begin
            for (int i = (2 ** (l + 1)) + (2 ** l) - 1; i < W; i += 2 ** (l + 1)) begin
                grp_g_s[i] = grp_g_s[i] | (grp_p_s[i] & grp_g_s[i - (2 ** l)]);
                grp_p_s[i] = grp_p_s[i] & grp_p_s[i - (2 ** l)];
            end
        end
        S  = prop_s ^ {grp_g_s[W-2:0], CI};
        CO = grp_g_s[W-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and registered C/V/Z/N flags.
// Optional build macro ALU_SAT_EN: signed saturation for ADD/ADDC/SUB/SUBB.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int SELW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  logic            CIN,
    input  logic [SELW-1:0] SEL,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [W-1:0]    Y,
    output logic [3:0]      FLAGS
);
    logic          s1_valid_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          cin_q;
    alu_op_e       op_q;
    logic          out_valid_q;
    logic [W-1:0]  y_q;
    logic [3:0]    flags_q;

    logic          adv_s;
    logic [W-1:0]  add_x_s;
    logic [W-1:0]  add_y_s;
    logic          add_ci_s;
    logic [W-1:0]  sum_s;
    logic          co_s;
    logic          ovf_s;
    logic [W-1:0]  y_d;
    logic [W-1:0]  zn_src_s;
    logic          c_s;
    logic          v_s;
    logic [3:0]    flags_d;

    assign adv_s     = !out_valid_q || OUT_READY;
    assign IN_READY  = adv_s;
    assign OUT_VALID = out_valid_q;
    assign Y         = y_q;
    assign FLAGS     = flags_q;

    // Operand and carry-in steering for the single shared adder.
    always_comb begin
        add_x_s  = a_q;
        add_y_s  = b_q;
        add_ci_s = 1'b0;
        case (op_q)
            OP_ADD:  add_ci_s = 1'b0;
            OP_ADDC: add_ci_s = cin_q;
            OP_SUB:  begin add_y_s = ~b_q; add_ci_s = 1'b1;   end
            OP_SUBB: begin add_y_s = ~b_q; add_ci_s = ~cin_q; end
            OP_INC:  begin add_y_s = '0;   add_ci_s = 1'b1;   end
            OP_DEC:  begin add_y_s = '1;   add_ci_s = 1'b0;   end
            OP_CMP:  begin add_y_s = ~b_q; add_ci_s = 1'b1;   end
            default: add_ci_s = 1'b0;
        endcase
    end

    bk_adder #(.W(W)) u_adder (
        .X  (add_x_s),
        .Y  (add_y_s),
        .CI (add_ci_s),
        .S  (sum_s),
        .CO (co_s)
    );

    assign ovf_s = (add_x_s[W-1] == add_y_s[W-1]) && (sum_s[W-1] != add_x_s[W-1]);

    // Result and flag selection; CMP reports Z/N of the difference, not of Y.
    always_comb begin
        y_d = sum_s;
        c_s = 1'b0;
        v_s = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
                c_s = co_s;
                v_s = ovf_s;
`ifdef ALU_SAT_EN
                if (ovf_s) begin
                    y_d = sum_s[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
                end else begin
                    y_d = sum_s;
                end
`else
                y_d = sum_s;
`endif
            end
            OP_INC, OP_DEC: begin y_d = sum_s; c_s = co_s; v_s = ovf_s; end
            OP_AND:  y_d = a_q & b_q;
            OP_OR:   y_d = a_q | b_q;
            OP_XOR:  y_d = a_q ^ b_q;
            OP_NOT:  y_d = ~a_q;
            OP_SHL:  begin y_d = {a_q[W-2:0], 1'b0};     c_s = a_q[W-1]; end
            OP_SHR:  begin y_d = {1'b0, a_q[W-1:1]};     c_s = a_q[0];   end
            OP_ASR:  begin y_d = {a_q[W-1], a_q[W-1:1]}; c_s = a_q[0];   end
            OP_ROL:  begin y_d = {a_q[W-2:0], a_q[W-1]}; c_s = a_q[W-1]; end
            OP_PASS: y_d = b_q;
            OP_CMP:  begin y_d = '0; c_s = co_s; v_s = ovf_s; end
            default: y_d = '0;
        endcase
        zn_src_s = (op_q == OP_CMP) ? sum_s : y_d;
        flags_d         = 4'b0000;
        flags_d[FLAG_C] = c_s;
        flags_d[FLAG_V] = v_s;
        flags_d[FLAG_Z] = (zn_src_s == '0);
        flags_d[FLAG_N] = zn_src_s[W-1];
    end

    // Both stages move together whenever the output slot is free or being drained.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            op_q        <= OP_ADD;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= 4'b0000;
        end else if (adv_s) begin
            s1_valid_q  <= IN_VALID;
            out_valid_q <= s1_valid_q;
            if (IN_VALID) begin
                a_q   <= A;
                b_q   <= B;
                cin_q <= CIN;
                op_q  <= alu_op_e'(SEL);
            end
            if (s1_valid_q) begin
                y_q     <= y_d;
                flags_q <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: W=8 instance with reference model, W=16 instance for wide-boundary cases.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready;
    logic [7:0]  a, b, y;
    logic [3:0]  sel, flags;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, y16;
    logic [3:0]  sel16, flags16;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] sb[$];
    logic [7:0]  held_y;

    always #5 clk = ~clk;

    alu_pipe #(.W(8), .SELW(4)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CIN(cin), .SEL(sel), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .Y(y), .FLAGS(flags)
    );

    alu_pipe #(.W(16), .SELW(4)) dut16 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid16), .IN_READY(in_ready16),
        .A(a16), .B(b16), .CIN(1'b0), .SEL(sel16), .OUT_VALID(out_valid16),
        .OUT_READY(out_ready16), .Y(y16), .FLAGS(flags16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: returns {Y[7:0], C, V, Z, N} for the 8-bit instance.
    function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mc, input logic [3:0] op);
        logic [8:0] w;
        logic [7:0] ry, diff;
        logic       c, v;
        int         sa, sbv, r;
        sa = $signed(ma); sbv = $signed(mb);
        ry = 8'h00; c = 1'b0; v = 1'b0; r = 0; diff = 8'h00;
        case (op)
            4'h0: begin w = {1'b0, ma} + {1'b0, mb}; c = w[8]; r = sa + sbv; end
            4'h1: begin w = {1'b0, ma} + {1'b0, mb} + {8'h00, mc}; c = w[8]; r = sa + sbv + int'(mc); end
            4'h2, 4'hF: begin w = {1'b0, ma} - {1'b0, mb}; c = ~w[8]; r = sa - sbv; end
            4'h3: begin w = {1'b0, ma} - {1'b0, mb} - {8'h00, mc}; c = ~w[8]; r = sa - sbv - int'(mc); end
            4'h4: begin w = {1'b0, ma} + 9'd1; c = w[8]; r = sa + 1; end
            4'h5: begin w = {1'b0, ma - 8'd1}; c = (ma != 8'h00); r = sa - 1; end
            default: w = 9'd0;
        endcase
        if (op <= 4'h5 || op == 4'hF) begin
            ry = w[7:0];
            v  = (r > 127) || (r < -128);
        end
        case (op)
            4'h6: ry = ma & mb;
            4'h7: ry = ma | mb;
            4'h8: ry = ma ^ mb;
            4'h9: ry = ~ma;
            4'hA: begin ry = ma << 1; c = ma[7]; end
            4'hB: begin ry = ma >> 1; c = ma[0]; end
            4'hC: begin ry = 8'($signed(ma) >>> 1); c = ma[0]; end
            4'hD: begin ry = {ma[6:0], ma[7]}; c = ma[7]; end
            4'hE: ry = mb;
            default: ;
        endcase
`ifdef ALU_SAT_EN
        if (op <= 4'h3 && v) ry = (r > 127) ? 8'h7F : 8'h80;
`endif
        diff = ry;
        if (op == 4'hF) begin
            diff = w[7:0];
            ry   = 8'h00;
        end
        return {ry, c, v, (diff == 8'h00), diff[7]};
    endfunction

    // Called just after a falling edge with inputs driven; books transfers then advances one cycle.
    task automatic tick();
        logic [11:0] e;
        #1;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("y", 64'(y), 64'(e[11:4]));
                    check("flags", 64'(flags), 64'(e[3:0]));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, cin, sel));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                         input logic dc, input logic [3:0] ds);
        in_valid = v; a = da; b = db; cin = dc; sel = ds;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 12 && sb.size() > 0; k++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = 16'h0; b16 = 16'h0; sel16 = 4'h0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Single ADD beat: latency and spec values
        drive(1'b1, 8'h93, 8'hA7, 1'b0, 4'h0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
        #1 check("lat_t1_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_t2_valid", 64'(out_valid), 64'd1);
        check("add_y", 64'(y), 64'h3A);
        check("add_flags", 64'(flags), 64'b1100);
        drain();

        // Opcode sweep back-to-back
        for (int s = 0; s < 16; s++) begin
            drive(1'b1, 8'h93, 8'hA7, (s == 1), 4'(s));
            tick();
        end
        drain();

        // Backpressure: fill, then stall five cycles
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            tick();
        end
        out_ready = 1'b0;
        held_y = y;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_y_stable", 64'(y), 64'(held_y));
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            tick();
        end
        drain();

        // Saturation boundary cases (wrap expectations when the macro is absent)
        drive(1'b1, 8'h7F, 8'h01, 1'b0, 4'h0); tick();
        drive(1'b1, 8'h80, 8'h01, 1'b0, 4'h2); tick();
        drain();

        // Reset with two ops in flight
        drive(1'b1, 8'h11, 8'h22, 1'b0, 4'h0); tick();
        drive(1'b1, 8'h33, 8'h44, 1'b0, 4'h8); tick();
        rst = 1'b1; drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
        tick();
        sb.delete();
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_y", 64'(y), 64'd0);
        check("midrst_flags", 64'(flags), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_stale_output", 64'(out_valid), 64'd0);
        end

        // W=16 boundaries
        in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; sel16 = 4'h0;
        @(posedge clk); @(negedge clk);
        in_valid16 = 1'b1; a16 = 16'h0000; b16 = 16'h0000; sel16 = 4'h5;
        @(posedge clk); @(negedge clk);
        in_valid16 = 1'b0;
        check("w16_add_valid", 64'(out_valid16), 64'd1);
        check("w16_add_y", 64'(y16), 64'h0000);
        check("w16_add_flags", 64'(flags16), 64'b1010);
        @(posedge clk); @(negedge clk);
        check("w16_dec_valid", 64'(out_valid16), 64'd1);
        check("w16_dec_y", 64'(y16), 64'hFFFF);
        check("w16_dec_flags", 64'(flags16), 64'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
